seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver_if.sv | 27 ++
 rtl/seg7_scan_driver.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_if.sv
// ============================================================================
// seg7_scan_driver_if : scan-enable, digit data and display pins of the driver
// Rev 1.0
// ============================================================================
`default_nettype none

interface seg7_scan_driver_if;
  logic        en;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  modport master (
    output en, bcd_in, dp_in,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  en, bcd_in, dp_in,
    output seg, dp, an, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver : 4-digit multiplexed 7-segment scanner with frame snapshot.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned     C_PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [C_PW-1:0] C_PMAX = C_PW'(SCAN_DIV - 1);
  localparam logic [6:0]      C_SEG_OFF = 7'h7F;

  logic [C_PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     snap_bcd_q, snap_bcd_d;
  logic [3:0]      snap_dp_q, snap_dp_d;
  logic            primed_q, primed_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      an_q, an_d;
  logic            frame_done_q, frame_done_d;

  logic            tc;
  logic            frame_end;
  logic [3:0]      cur_digit;
  logic [6:0]      cur_seg;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h40;
      4'd1:    f_decode = 7'h79;
      4'd2:    f_decode = 7'h24;
      4'd3:    f_decode = 7'h30;
      4'd4:    f_decode = 7'h19;
      4'd5:    f_decode = 7'h12;
      4'd6:    f_decode = 7'h02;
      4'd7:    f_decode = 7'h78;
      4'd8:    f_decode = 7'h00;
      4'd9:    f_decode = 7'h10;
      default: f_decode = C_SEG_OFF;
    endcase
  endfunction

  always_comb begin
    tc        = bus.en && (pcnt_q == C_PMAX);
    frame_end = tc && (idx_q == 2'd3);
    cur_digit = snap_bcd_q[{idx_q, 2'b00} +: 4];
    cur_seg   = f_decode(cur_digit);
`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero.
    if (((idx_q == 2'd3) && (snap_bcd_q[15:12] == 4'd0)) ||
        ((idx_q == 2'd2) && (snap_bcd_q[15:8]  == 8'd0)) ||
        ((idx_q == 2'd1) && (snap_bcd_q[15:4]  == 12'd0)))
      cur_seg = C_SEG_OFF;
`endif
  end

  always_comb begin
    pcnt_d       = pcnt_q;
    idx_d        = idx_q;
    snap_bcd_d   = snap_bcd_q;
    snap_dp_d    = snap_dp_q;
    primed_d     = primed_q;
    an_d         = 4'hF;
    seg_d        = C_SEG_OFF;
    dp_d         = 1'b1;
    frame_done_d = 1'b0;

    if (bus.en) begin
      pcnt_d   = tc ? '0 : pcnt_q + 1'b1;
      primed_d = 1'b1;
      if (tc)
        idx_d = idx_q + 2'd1;
      // Snapshot only at frame boundaries so a frame never mixes two values.
      if (frame_end || !primed_q) begin
        snap_bcd_d = bus.bcd_in;
        snap_dp_d  = bus.dp_in;
      end

      an_d         = (pcnt_q == '0) ? 4'hF : ~(4'b0001 << idx_q);
      seg_d        = cur_seg;
      dp_d         = ~snap_dp_q[idx_q];
      frame_done_d = frame_end;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q       <= '0;
      idx_q        <= 2'd0;
      snap_bcd_q   <= 16'd0;
      snap_dp_q    <= 4'd0;
      primed_q     <= 1'b0;
      seg_q        <= C_SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      snap_bcd_q   <= snap_bcd_d;
      snap_dp_q    <= snap_dp_d;
      primed_q     <= primed_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire
